// File: rtl/bram_s18_pkg.sv
// Shared types and sizes for the 18-bit block-RAM arbiter slice.
package bram_s18_pkg;

    localparam int unsigned RAM_DEPTH = 1024;
    localparam int unsigned RAM_DW    = 16;
    localparam int unsigned RAM_PW    = 2;

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;
    typedef enum logic {PORT_A, PORT_B} port_e;

endpackage

// File: rtl/bram_s18_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered priority pointer.
module rr_arb2
    import bram_s18_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_e ptr_q, ptr_d;

    always_comb begin
        gnt = '0;
        if (en) begin
            if (req == 2'b11) gnt = (ptr_q == PORT_A) ? 2'b01 : 2'b10;
            else              gnt = req;
        end
        // The pointer moves to the loser after any grant, holds otherwise.
        ptr_d = ptr_q;
        if (gnt[0])      ptr_d = PORT_B;
        else if (gnt[1]) ptr_d = PORT_A;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= PORT_A;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bram_s18_arbiter.sv
// Shares one 1Kx18 single-port block RAM between ports A and B, with an
// optional post-reset clear sweep before any requester is served.
module bram_s18_arbiter
    import bram_s18_pkg::*;
#(
    parameter int unsigned           ADDR_W         = 10,
    parameter int unsigned           DATA_W         = 18,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0]     CLEAR_VAL      = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_WDATA,
    output logic              A_GNT,
    output logic              A_RVALID,
    output logic [DATA_W-1:0] A_RDATA,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_WDATA,
    output logic              B_GNT,
    output logic              B_RVALID,
    output logic [DATA_W-1:0] B_RDATA,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic              RAM_SSR,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [15:0]       RAM_DI,
    output logic [1:0]        RAM_DIP,
    input  logic [15:0]       RAM_DO,
    input  logic [1:0]        RAM_DOP,
    output logic              BUSY
);

    localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                rsp_vld_q, rsp_vld_d;
    port_e               rsp_owner_q, rsp_owner_d;

    logic [1:0]          gnt;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    rr_arb2 u_arb (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (state_q == ST_RUN),
        .req   ({B_REQ, A_REQ}),
        .gnt   (gnt)
    );

    assign A_GNT   = gnt[0];
    assign B_GNT   = gnt[1];
    assign RAM_SSR = 1'b0;
    assign BUSY    = busy_q;

    always_comb begin
        win_we    = gnt[1] ? B_WE    : A_WE;
        win_addr  = gnt[1] ? B_ADDR  : A_ADDR;
        win_wdata = gnt[1] ? B_WDATA : A_WDATA;

        RAM_EN   = 1'b0;
        RAM_WE   = 1'b0;
        RAM_ADDR = '0;
        RAM_DI   = '0;
        RAM_DIP  = '0;

        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_vld_d   = 1'b0;
        rsp_owner_d = gnt[1] ? PORT_B : PORT_A;

        if (state_q == ST_CLEAR) begin
            RAM_EN   = 1'b1;
            RAM_WE   = 1'b1;
            RAM_ADDR = cnt_q;
            RAM_DI   = CLEAR_VAL[RAM_DW-1:0];
            RAM_DIP  = CLEAR_VAL[RAM_DW +: RAM_PW];
            cnt_d    = cnt_q + ADDR_W'(1);
            if (cnt_q == '1) state_d = ST_RUN;
        end else if (|gnt) begin
            RAM_EN    = 1'b1;
            RAM_WE    = win_we;
            RAM_ADDR  = win_addr;
            RAM_DI    = win_wdata[RAM_DW-1:0];
            RAM_DIP   = win_wdata[RAM_DW +: RAM_PW];
            rsp_vld_d = !win_we;
        end

        busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            busy_q      <= CLEAR_ON_RESET;
            rsp_vld_q   <= 1'b0;
            rsp_owner_q <= PORT_A;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    // Read data is a straight pass-through of the RAM output to the owning port.
    always_comb begin
        A_RVALID = rsp_vld_q && (rsp_owner_q == PORT_A);
        B_RVALID = rsp_vld_q && (rsp_owner_q == PORT_B);
        A_RDATA  = A_RVALID ? {RAM_DOP, RAM_DO} : '0;
        B_RDATA  = B_RVALID ? {RAM_DOP, RAM_DO} : '0;
    end

endmodule

// File: tb/tb_bram_s18_arbiter.sv
// Scoreboard bench: reference model predicts per-cycle grants, RAM drive and read data.
module tb_bram_s18_arbiter;

    localparam int unsigned DEPTH = 1024;
    localparam logic [17:0] CV    = 18'h3A5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: clear sweep enabled
    logic        rst_n, a_req, a_we, b_req, b_we;
    logic [9:0]  a_addr, b_addr;
    logic [17:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic        ram_en, ram_we, ram_ssr, busy;
    logic [9:0]  ram_addr;
    logic [15:0] ram_di, ram_do;
    logic [1:0]  ram_dip, ram_dop;

    bram_s18_arbiter #(.ADDR_W(10), .DATA_W(18), .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(CV)) dut (
        .CLK(clk), .RST_N(rst_n),
        .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
        .A_GNT(a_gnt), .A_RVALID(a_rvalid), .A_RDATA(a_rdata),
        .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
        .B_GNT(b_gnt), .B_RVALID(b_rvalid), .B_RDATA(b_rdata),
        .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_SSR(ram_ssr), .RAM_ADDR(ram_addr),
        .RAM_DI(ram_di), .RAM_DIP(ram_dip), .RAM_DO(ram_do), .RAM_DOP(ram_dop),
        .BUSY(busy)
    );

    // DUT 1: no clear sweep
    logic        z_rst_n, z_a_req, z_a_we, z_b_req, z_b_we;
    logic [9:0]  z_a_addr, z_b_addr;
    logic [17:0] z_a_wdata, z_b_wdata, z_a_rdata, z_b_rdata;
    logic        z_a_gnt, z_b_gnt, z_a_rvalid, z_b_rvalid;
    logic        z_ram_en, z_ram_we, z_ram_ssr, z_busy;
    logic [9:0]  z_ram_addr;
    logic [15:0] z_ram_di, z_ram_do;
    logic [1:0]  z_ram_dip, z_ram_dop;

    bram_s18_arbiter #(.ADDR_W(10), .DATA_W(18), .CLEAR_ON_RESET(1'b0), .CLEAR_VAL(18'h0)) dut_nc (
        .CLK(clk), .RST_N(z_rst_n),
        .A_REQ(z_a_req), .A_WE(z_a_we), .A_ADDR(z_a_addr), .A_WDATA(z_a_wdata),
        .A_GNT(z_a_gnt), .A_RVALID(z_a_rvalid), .A_RDATA(z_a_rdata),
        .B_REQ(z_b_req), .B_WE(z_b_we), .B_ADDR(z_b_addr), .B_WDATA(z_b_wdata),
        .B_GNT(z_b_gnt), .B_RVALID(z_b_rvalid), .B_RDATA(z_b_rdata),
        .RAM_EN(z_ram_en), .RAM_WE(z_ram_we), .RAM_SSR(z_ram_ssr), .RAM_ADDR(z_ram_addr),
        .RAM_DI(z_ram_di), .RAM_DIP(z_ram_dip), .RAM_DO(z_ram_do), .RAM_DOP(z_ram_dop),
        .BUSY(z_busy)
    );

    // Behavioural RAM primitives (synchronous read, write-first)
    logic [17:0] ram0 [DEPTH];
    logic [17:0] ram1 [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram0[ram_addr] <= {ram_dip, ram_di};
                {ram_dop, ram_do} <= {ram_dip, ram_di};
            end else begin
                {ram_dop, ram_do} <= ram0[ram_addr];
            end
        end
    end
    always @(posedge clk) begin
        if (z_ram_en) begin
            if (z_ram_we) begin
                ram1[z_ram_addr] <= {z_ram_dip, z_ram_di};
                {z_ram_dop, z_ram_do} <= {z_ram_dip, z_ram_di};
            end else begin
                {z_ram_dop, z_ram_do} <= ram1[z_ram_addr];
            end
        end
    end

    typedef struct packed {
        logic        a_gnt, b_gnt, a_rv, b_rv, busy, en, we;
        logic [9:0]  addr;
        logic [17:0] di;
    } exp_t;

    exp_t        gq[$];
    logic [17:0] rq[$];

    int ncmp = 0;
    int nerr = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model state
    logic [17:0] mref [DEPTH];
    int          clear_left = 0;
    bit          pri_b      = 1'b0;
    int          pend       = 0;   // 0 none, 1 A, 2 B

    task automatic cyc(input bit rst, input bit ar, input bit aw, input logic [9:0] aa,
                       input logic [17:0] ad, input bit br, input bit bw,
                       input logic [9:0] ba, input logic [17:0] bd, input bit check);
        exp_t e;
        int   win;
        int   new_pend;
        @(posedge clk);
        #1;
        rst_n = rst;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        e        = '0;
        e.a_rv   = (pend == 1);
        e.b_rv   = (pend == 2);
        new_pend = 0;
        if (clear_left > 0) begin
            e.busy = 1'b1; e.en = 1'b1; e.we = 1'b1; e.di = CV;
            e.addr = 10'(DEPTH - clear_left);
            mref[DEPTH - clear_left] = CV;
            clear_left--;
        end else begin
            win = 0;
            if (ar && br) win = pri_b ? 2 : 1;
            else if (ar)  win = 1;
            else if (br)  win = 2;
            if (win != 0) begin
                e.en   = 1'b1;
                e.we   = (win == 1) ? aw : bw;
                e.addr = (win == 1) ? aa : ba;
                e.di   = (win == 1) ? ad : bd;
                if (win == 1) e.a_gnt = 1'b1; else e.b_gnt = 1'b1;
                if (e.we) mref[e.addr] = e.di;
                else if (rst) begin
                    rq.push_back(mref[e.addr]);
                    new_pend = win;
                end
                pri_b = (win == 1);
            end
        end
        if (!rst) begin
            clear_left = DEPTH;
            pri_b      = 1'b0;
            new_pend   = 0;
        end
        pend = new_pend;
        if (check) gq.push_back(e);
    endtask

    task automatic rnd_cyc(input int amax);
        cyc(1'b1, 1'($urandom), 1'($urandom), 10'($urandom_range(0, amax)), 18'($urandom),
            1'($urandom), 1'($urandom), 10'($urandom_range(0, amax)), 18'($urandom), 1'b1);
    endtask

    // Monitor: pops the per-cycle expectation and any read data due this cycle
    exp_t        m_e;
    logic [17:0] m_d;
    always @(negedge clk) begin
        if (gq.size() > 0) begin
            m_e = gq.pop_front();
            chk("a_gnt", 32'(a_gnt), 32'(m_e.a_gnt));
            chk("b_gnt", 32'(b_gnt), 32'(m_e.b_gnt));
            chk("a_rvalid", 32'(a_rvalid), 32'(m_e.a_rv));
            chk("b_rvalid", 32'(b_rvalid), 32'(m_e.b_rv));
            chk("busy", 32'(busy), 32'(m_e.busy));
            chk("ram_en", 32'(ram_en), 32'(m_e.en));
            chk("ram_we", 32'(ram_we), 32'(m_e.we));
            chk("ram_addr", 32'(ram_addr), 32'(m_e.addr));
            chk("ram_di", 32'({ram_dip, ram_di}), 32'(m_e.di));
            chk("ram_ssr", 32'(ram_ssr), 32'(0));
            m_d = 18'h0;
            if ((m_e.a_rv || m_e.b_rv) && rq.size() > 0) m_d = rq.pop_front();
            chk("a_rdata", 32'(a_rdata), m_e.a_rv ? 32'(m_d) : 32'(0));
            chk("b_rdata", 32'(b_rdata), m_e.b_rv ? 32'(m_d) : 32'(0));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        z_rst_n = 1'b0; z_a_req = 1'b0; z_a_we = 1'b0; z_a_addr = '0; z_a_wdata = '0;
        z_b_req = 1'b0; z_b_we = 1'b0; z_b_addr = '0; z_b_wdata = '0;

        // Reset, then full clear sweep with requests arriving and held off
        cyc(1'b0, 0, 0, '0, '0, 0, 0, '0, '0, 1'b0);
        cyc(1'b0, 0, 0, '0, '0, 0, 0, '0, '0, 1'b1);
        for (int i = 0; i < DEPTH - 8; i++) rnd_cyc(1023);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1, 0, 10'h3FF, '0, 0, 0, '0, '0, 1'b1);

        // First RUN cycle: A read of the last cleared location
        cyc(1'b1, 1, 0, 10'h3FF, '0, 0, 0, '0, '0, 1'b1);
        cyc(1'b1, 0, 0, '0, '0, 0, 0, '0, '0, 1'b1);

        // A write then read-back of the same address
        cyc(1'b1, 1, 1, 10'h010, 18'h11234, 0, 0, '0, '0, 1'b1);
        cyc(1'b1, 1, 0, 10'h010, '0, 0, 0, '0, '0, 1'b1);
        cyc(1'b1, 0, 0, '0, '0, 0, 0, '0, '0, 1'b1);

        // Both ports contend: grants must alternate
        cyc(1'b1, 1, 1, 10'h001, 18'h0AAAA, 1, 1, 10'h002, 18'h25555, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1, 0, 10'h001, '0, 1, 0, 10'h002, '0, 1'b1);
        cyc(1'b1, 0, 0, '0, '0, 0, 0, '0, '0, 1'b1);

        // Random traffic over a small address window for read/write hazards
        for (int i = 0; i < 400; i++) rnd_cyc(15);

        // Reset with B reads in flight; sweep must restart at address 0
        cyc(1'b1, 0, 0, '0, '0, 1, 0, 10'h002, '0, 1'b1);
        cyc(1'b0, 0, 0, '0, '0, 1, 0, 10'h001, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) rnd_cyc(1023);
        for (int i = 0; i < 200; i++) rnd_cyc(31);
        cyc(1'b1, 0, 0, '0, '0, 0, 0, '0, '0, 1'b1);
        cyc(1'b1, 0, 0, '0, '0, 0, 0, '0, '0, 1'b1);
        @(posedge clk);
        chk("sb_drain", 32'(gq.size() + rq.size()), 32'(0));

        // No-clear instance: served in the first cycle after reset release
        @(posedge clk); #1;
        chk("nc_busy_reset", 32'(z_busy), 32'(0));
        z_rst_n = 1'b1; z_a_req = 1'b1; z_a_we = 1'b1; z_a_addr = 10'h005; z_a_wdata = 18'h2BEEF;
        @(negedge clk);
        chk("nc_busy", 32'(z_busy), 32'(0));
        chk("nc_a_gnt_wr", 32'(z_a_gnt), 32'(1));
        chk("nc_ram_we", 32'(z_ram_we), 32'(1));
        @(posedge clk); #1;
        z_a_we = 1'b0; z_b_req = 1'b0;
        @(negedge clk);
        chk("nc_a_gnt_rd", 32'(z_a_gnt), 32'(1));
        chk("nc_a_rvalid_early", 32'(z_a_rvalid), 32'(0));
        @(posedge clk); #1;
        z_a_req = 1'b0;
        @(negedge clk);
        chk("nc_a_rvalid", 32'(z_a_rvalid), 32'(1));
        chk("nc_a_rdata", 32'(z_a_rdata), 32'(18'h2BEEF));
        chk("nc_b_rvalid", 32'(z_b_rvalid), 32'(0));
        chk("nc_b_rdata", 32'(z_b_rdata), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
